// File: rtl/alu_decode.sv
// alu_decode: Beta ALU decode/operand stage feeding execute through a 2-entry skid buffer.
// Define ALU_DECODE_BYPASS_EN to forward writeback data into the register operands.
module alu_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  rf_ra_addr,
    output logic [4:0]  rf_rb_addr,
    input  logic [31:0] rf_ra_data,
    input  logic [31:0] rf_rb_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_fn,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rc,
    output logic        out_illegal
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    // payload layout: {illegal, fn, rc, a, b}
    localparam logic [75:0] PL_RST = {1'b0, 6'd0, 5'd31, 64'd0};

    logic [5:0]  op;
    logic [4:0]  rc, ra, rb;
    logic [5:0]  fn;
    logic        legal;
    logic        byp_a, byp_b;
    logic [31:0] a_d, b_d;
    logic [75:0] pl_d, out_q, skid_q;
    state_t      state_q;
    logic        in_ready_q, out_valid_q;

    assign op = in_instr[31:26];
    assign rc = in_instr[25:21];
    assign ra = in_instr[20:16];
    assign rb = in_instr[15:11];
    assign rf_ra_addr = ra;
    assign rf_rb_addr = rb;

`ifdef ALU_DECODE_BYPASS_EN
    assign byp_a = wb_we && wb_addr == ra && ra != 5'd31;
    assign byp_b = wb_we && wb_addr == rb && rb != 5'd31;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr};
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    always_comb begin
        fn = 6'b010000;
        legal = op[5];
        case (op[3:0])
            4'h0: fn = 6'b010000;
            4'h1: fn = 6'b010001;
            4'h4: fn = 6'b000011;
            4'h5: fn = 6'b000101;
            4'h6: fn = 6'b000111;
            4'h8: fn = 6'b101000;
            4'h9: fn = 6'b101110;
            4'hA: fn = 6'b100110;
            4'hB: fn = 6'b101001;
            4'hC: fn = 6'b110000;
            4'hD: fn = 6'b110001;
            4'hE: fn = 6'b110011;
            default: legal = 1'b0;
        endcase
    end

    assign a_d = (ra == 5'd31) ? 32'd0 : byp_a ? wb_data : rf_ra_data;
    assign b_d = op[4] ? {{16{in_instr[15]}}, in_instr[15:0]}
               : (rb == 5'd31) ? 32'd0 : byp_b ? wb_data : rf_rb_data;
    assign pl_d = legal ? {1'b0, fn, rc, a_d, b_d} : {1'b1, 6'b010000, 5'd31, 64'd0};

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign {out_illegal, out_fn, out_rc, out_a, out_b} = out_q;

    // in_ready_q is high in EMPTY and ONE, so in_valid alone marks an accept there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= PL_RST;
            skid_q      <= PL_RST;
        end else begin
            case (state_q)
                EMPTY: if (in_valid) begin
                    out_q       <= pl_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ONE;
                end
                ONE: if (in_valid && out_ready) begin
                    out_q <= pl_d;
                end else if (in_valid) begin
                    skid_q     <= pl_d;
                    in_ready_q <= 1'b0;
                    state_q    <= FULL;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= EMPTY;
                end
                FULL: if (out_ready) begin
                    out_q      <= skid_q;
                    in_ready_q <= 1'b1;
                    state_q    <= ONE;
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
